// File: rtl/fetch_sequencer_pkg.sv
// fetch_sequencer_pkg
//   Types and constants shared by the fetch sequencer and the control decoder.
//   state_t : sequencer FSM states
//   stage_t : 2-bit stage code driven to the control decoder
//   HALT_OP : opcode that ends the program
package fetch_sequencer_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FETCH,
        ST_EXEC,
        ST_UPDATE,
        ST_HALT
    } state_t;

    typedef enum logic [1:0] {
        STG_FETCH  = 2'b00,
        STG_EXEC   = 2'b01,
        STG_UPDATE = 2'b10
    } stage_t;

    localparam logic [4:0] HALT_OP = 5'b11111;

endpackage

// File: rtl/fetch_sequencer_return_stack.sv
// return_stack
//   Return-address stack for the fetch sequencer.
//   Optional feature macro: FETCH_STACK_ERR_EN
//     defined   : sp has one extra bit; pushes when full and pops when empty
//                 are dropped, and full/empty are exported for error flagging.
//     undefined : sp wraps modulo DEPTH (overflow overwrites the oldest entry).
//   Ports:
//     clk, reset : clock, async active-high reset (clears sp only)
//     push, pop  : one-cycle requests (never both at once)
//     din        : address pushed
//     dout       : current top entry, stack[sp-1]
//     full/empty : only with FETCH_STACK_ERR_EN
module return_stack #(
    parameter int PCW   = 10,
    parameter int DEPTH = 4
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           push,
    input  logic           pop,
    input  logic [PCW-1:0] din,
    output logic [PCW-1:0] dout
`ifdef FETCH_STACK_ERR_EN
    ,
    output logic           full,
    output logic           empty
`endif
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
`ifdef FETCH_STACK_ERR_EN
    localparam int SPW = AW + 1;
`else
    localparam int SPW = AW;
`endif

    logic [SPW-1:0] sp;
    logic [PCW-1:0] mem [DEPTH];
    logic [AW-1:0]  wr_idx;
    logic [AW-1:0]  rd_idx;
    logic           do_push;
    logic           do_pop;

    assign wr_idx = sp[AW-1:0];
    // Low sp bits minus one wraps, so an empty pop reads the last slot.
    assign rd_idx = sp[AW-1:0] - AW'(1);
    assign dout   = mem[rd_idx];

`ifdef FETCH_STACK_ERR_EN
    assign full    = (sp == SPW'(DEPTH));
    assign empty   = (sp == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
`else
    assign do_push = push;
    assign do_pop  = pop;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sp <= '0;
        end else if (do_push) begin
            sp <= sp + SPW'(1);
        end else if (do_pop) begin
            sp <= sp - SPW'(1);
        end
    end

    // Storage is intentionally not reset.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_idx] <= din;
        end
    end

endmodule

// File: rtl/fetch_sequencer.sv
// fetch_sequencer
//   Multi-cycle front end: fetches one instruction per FETCH/EXEC/UPDATE pass,
//   latches it for the control decoder and computes the next PC from the
//   decoder's jump/call/ret outputs using a return-address stack.
//   Optional feature macro: FETCH_STACK_ERR_EN (adds sticky stack_err output
//   and saturating stack boundaries).
//   Ports:
//     clk, reset      : clock, async active-high reset
//     start           : pulse in IDLE begins execution from PC 0
//     instr_in        : ROM data at address pc
//     jump/call/ret   : decoder outputs, sampled in UPDATE only
//     branch_taken    : condition result for conditional jumps
//     target          : jump/call destination
//     pc              : ROM address
//     opcode, operand : latched instruction fields
//     stage           : 00 fetch, 01 execute, 10 PC update
//     done            : program halted
//     stack_err       : only with FETCH_STACK_ERR_EN
module fetch_sequencer #(
    parameter int         PCW     = 10,
    parameter int         IW      = 9,
    parameter int         DEPTH   = 4,
    parameter logic [4:0] HALT_OP = fetch_sequencer_pkg::HALT_OP
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    input  logic [IW-1:0] instr_in,
    input  logic          jump,
    input  logic          call,
    input  logic          ret,
    input  logic          branch_taken,
    input  logic [PCW-1:0] target,
    output logic [PCW-1:0] pc,
    output logic [4:0]    opcode,
    output logic [IW-6:0] operand,
    output logic [1:0]    stage,
    output logic          done
`ifdef FETCH_STACK_ERR_EN
    ,
    output logic          stack_err
`endif
);

    import fetch_sequencer_pkg::*;

    state_t         state;
    state_t         state_nxt;
    logic [IW-1:0]  ir;
    logic [PCW-1:0] pc_inc;
    logic [PCW-1:0] pc_nxt;
    logic [PCW-1:0] ret_addr;
    logic           in_update;
    logic           do_push;
    logic           do_pop;
`ifdef FETCH_STACK_ERR_EN
    logic           stk_full;
    logic           stk_empty;
`endif

    assign opcode  = ir[IW-1:IW-5];
    assign operand = ir[IW-6:0];

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        unique case (state)
            ST_IDLE:   if (start) state_nxt = ST_FETCH;
            ST_FETCH:  state_nxt = (instr_in[IW-1:IW-5] == HALT_OP) ? ST_HALT : ST_EXEC;
            ST_EXEC:   state_nxt = ST_UPDATE;
            ST_UPDATE: state_nxt = ST_FETCH;
            ST_HALT:   state_nxt = ST_HALT;
            default:   state_nxt = ST_IDLE;
        endcase
    end

    // Outputs
    always_comb begin
        stage = STG_FETCH;
        done  = 1'b0;
        unique case (state)
            ST_EXEC:   stage = STG_EXEC;
            ST_UPDATE: stage = STG_UPDATE;
            ST_HALT:   done  = 1'b1;
            default:   ;
        endcase
    end

    assign in_update = (state == ST_UPDATE);
    assign pc_inc    = pc + PCW'(1);
    // ret outranks call, so a simultaneous call must not push.
    assign do_pop    = in_update && ret;
    assign do_push   = in_update && !ret && call;

    always_comb begin
        pc_nxt = pc_inc;
        if (ret) begin
`ifdef FETCH_STACK_ERR_EN
            if (!stk_empty) pc_nxt = ret_addr;
`else
            pc_nxt = ret_addr;
`endif
        end else if (call || (jump && branch_taken)) begin
            pc_nxt = target;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc <= '0;
            ir <= '0;
        end else begin
            if (state == ST_FETCH) ir <= instr_in;
            if (in_update)         pc <= pc_nxt;
        end
    end

`ifdef FETCH_STACK_ERR_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stack_err <= 1'b0;
        end else if ((do_pop && stk_empty) || (do_push && stk_full)) begin
            stack_err <= 1'b1;
        end
    end
`endif

    return_stack #(
        .PCW   (PCW),
        .DEPTH (DEPTH)
    ) u_return_stack (
        .clk   (clk),
        .reset (reset),
        .push  (do_push),
        .pop   (do_pop),
        .din   (pc_inc),
        .dout  (ret_addr)
`ifdef FETCH_STACK_ERR_EN
        ,
        .full  (stk_full),
        .empty (stk_empty)
`endif
    );

endmodule

// File: tb/tb_fetch_sequencer.sv
`timescale 1ns/1ps
module tb_fetch_sequencer;

    localparam int PCW   = 10;
    localparam int IW    = 9;
    localparam int DEPTH = 4;
    localparam logic [4:0] HOP = 5'b11111;

    logic           clk = 1'b0;
    logic           reset;
    logic           start;
    logic [IW-1:0]  instr_in;
    logic           jump, call, ret, branch_taken;
    logic [PCW-1:0] target;
    logic [PCW-1:0] pc;
    logic [4:0]     opcode;
    logic [3:0]     operand;
    logic [1:0]     stage;
    logic           done;
`ifdef FETCH_STACK_ERR_EN
    logic           stack_err;
`endif

    logic [IW-1:0] rom [1 << PCW];
    assign instr_in = rom[pc];

    always #5 clk = ~clk;

    fetch_sequencer #(
        .PCW   (PCW),
        .IW    (IW),
        .DEPTH (DEPTH)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .start        (start),
        .instr_in     (instr_in),
        .jump         (jump),
        .call         (call),
        .ret          (ret),
        .branch_taken (branch_taken),
        .target       (target),
        .pc           (pc),
        .opcode       (opcode),
        .operand      (operand),
        .stage        (stage),
        .done         (done)
`ifdef FETCH_STACK_ERR_EN
        ,
        .stack_err    (stack_err)
`endif
    );

    int vectors = 0;
    int miscompares = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Reference model: architectural PC plus an abstract return stack.
    int  m_pc;
    bit  m_err;
    bit  m_halted;
    int  m_q[$];          // bounded stack when errors are enabled
    int  m_arr[DEPTH];    // circular stack otherwise
    bit  m_val[DEPTH];
    int  m_sp;

    task automatic model_reset();
        m_pc = 0; m_err = 0; m_halted = 0; m_sp = 0;
        m_q.delete();
        foreach (m_val[i]) m_val[i] = 0;
    endtask

    task automatic model_step(input bit j, input bit c, input bit r, input bit bt, input int tgt);
        int npc;
        if (r) begin
`ifdef FETCH_STACK_ERR_EN
            if (m_q.size() == 0) begin
                m_err = 1; npc = m_pc + 1;
            end else begin
                npc = m_q.pop_back();
            end
`else
            m_sp = (m_sp + DEPTH - 1) % DEPTH;
            npc  = m_arr[m_sp];
`endif
        end else if (c) begin
`ifdef FETCH_STACK_ERR_EN
            if (m_q.size() == DEPTH) m_err = 1;
            else m_q.push_back((m_pc + 1) % (1 << PCW));
`else
            m_arr[m_sp] = (m_pc + 1) % (1 << PCW);
            m_val[m_sp] = 1;
            m_sp = (m_sp + 1) % DEPTH;
`endif
            npc = tgt;
        end else if (j && bt) begin
            npc = tgt;
        end else begin
            npc = m_pc + 1;
        end
        m_pc = npc % (1 << PCW);
    endtask

    task automatic garbage();
        jump = 1'($urandom); call = 1'($urandom); ret = 1'($urandom);
        branch_taken = 1'($urandom); target = PCW'($urandom);
    endtask

    task automatic fill_rom(input int halt_pct);
        for (int i = 0; i < (1 << PCW); i++) begin
            logic [4:0] op;
            op = 5'($urandom_range(0, 30));
            if (int'($urandom_range(0, 99)) < halt_pct) op = HOP;
            rom[i] = {op, 4'($urandom)};
        end
    endtask

    task automatic check_idle(input string tag);
        check({tag, "_pc"}, pc, 0);
        check({tag, "_opcode"}, opcode, 0);
        check({tag, "_operand"}, operand, 0);
        check({tag, "_stage"}, stage, 0);
        check({tag, "_done"}, done, 0);
`ifdef FETCH_STACK_ERR_EN
        check({tag, "_stack_err"}, stack_err, 0);
`endif
    endtask

    task automatic do_reset();
        reset = 1'b1; start = 1'b0; garbage();
        @(negedge clk);
        check_idle("rst");
        reset = 1'b0;
        model_reset();
        @(negedge clk);
        check_idle("idle");
    endtask

    task automatic do_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Entered at the negedge of a FETCH cycle; leaves at the next one.
    task automatic do_instr(input bit j, input bit c, input bit r, input bit bt, input int tgt);
        logic [IW-1:0] cur;
        check("fetch_pc", pc, m_pc);
        check("fetch_stage", stage, 0);
        check("fetch_done", done, 0);
`ifdef FETCH_STACK_ERR_EN
        check("stack_err", stack_err, m_err);
`endif
        cur = rom[m_pc];
        @(negedge clk);
        if (cur[8:4] == HOP) begin
            m_halted = 1;
            check("halt_done", done, 1);
            check("halt_stage", stage, 0);
            check("halt_pc", pc, m_pc);
            check("halt_opcode", opcode, HOP);
            return;
        end
        check("exec_stage", stage, 1);
        check("exec_opcode", opcode, cur[8:4]);
        check("exec_operand", operand, cur[3:0]);
        @(negedge clk);
        check("upd_stage", stage, 2);
        check("upd_opcode", opcode, cur[8:4]);
        jump = j; call = c; ret = r; branch_taken = bt; target = PCW'(tgt);
        model_step(j, c, r, bt, tgt);
        @(negedge clk);
        garbage();
    endtask

    task automatic plain(input int n);
        for (int i = 0; i < n; i++) do_instr(0, 0, 0, 0, 0);
    endtask

    task automatic rand_instr();
        bit j, c, r, bt;
        int k;
        k  = int'($urandom_range(0, 9));
        r  = (k < 2);
        c  = (k >= 2 && k < 4) || (r && ($urandom_range(0, 1) == 1));
        j  = 1'($urandom);
        bt = 1'($urandom);
`ifndef FETCH_STACK_ERR_EN
        if (r && !m_val[(m_sp + DEPTH - 1) % DEPTH]) r = 0;
`endif
        do_instr(j, c, r, bt, int'($urandom_range(0, (1 << PCW) - 1)));
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: got no finish, expected finish before time limit");
        $fatal(1);
    end

    initial begin
        reset = 1'b1; start = 1'b0;
        jump = 0; call = 0; ret = 0; branch_taken = 0; target = '0;

        // Straight-line program ending in HALT
        fill_rom(0);
        rom[3] = {HOP, 4'h0};
        do_reset();
        do_start();
        plain(3);
        do_instr(0, 0, 0, 0, 0);
        check("halted_model", m_halted, 1);
        repeat (3) @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        check("halt_hold_done", done, 1);
        check("halt_hold_pc", pc, 3);
        check("halt_hold_stage", stage, 0);

        // Conditional jumps at PC 5 / 6
        fill_rom(0);
        do_reset();
        do_start();
        plain(5);
        do_instr(1, 0, 0, 0, 40);
        do_instr(1, 0, 0, 1, 5);
        do_instr(1, 0, 0, 1, 40);
        check("jump_pc40", pc, 40);

        // call at 7 -> 100, ret at 100 -> 8
        do_reset();
        do_start();
        plain(7);
        do_instr(0, 1, 0, 0, 100);
        do_instr(0, 0, 1, 0, 0);
        check("ret_pc8", pc, 8);
        do_instr(0, 1, 0, 0, 300);
        do_instr(0, 0, 1, 0, 0);
        check("ret_pc9", pc, 9);

        // Five nested calls, then unwinding
        do_reset();
        do_start();
        do_instr(0, 1, 0, 0, 200);
        do_instr(0, 1, 0, 0, 300);
        do_instr(0, 1, 0, 0, 400);
        do_instr(0, 1, 0, 0, 500);
        do_instr(0, 1, 0, 0, 600);
        for (int i = 0; i < 4; i++) do_instr(0, 0, 1, 0, 0);
`ifdef FETCH_STACK_ERR_EN
        check("nest_last_ret", pc, 1);
        check("nest_err", stack_err, 1);
        do_instr(0, 0, 1, 0, 0);
        check("nest_empty_ret", pc, 2);
`else
        check("nest_last_ret", pc, 201);
`endif
        do_instr(0, 0, 0, 0, 0);

`ifdef FETCH_STACK_ERR_EN
        // Empty-stack return at PC 20
        do_reset();
        do_start();
        plain(20);
        do_instr(0, 0, 1, 0, 0);
        check("empty_ret_pc", pc, 21);
        check("empty_ret_err", stack_err, 1);
        do_instr(0, 0, 0, 0, 0);
`endif

        // Reset in EXEC at PC 9, then re-run
        do_reset();
        do_start();
        plain(9);
        @(negedge clk);
        check("pre_rst_stage", stage, 1);
        check("pre_rst_pc", pc, 9);
        reset = 1'b1;
        #1;
        check_idle("mid_rst");
        @(negedge clk);
        reset = 1'b0;
        model_reset();
        @(negedge clk);
        do_start();
        plain(3);

        // Randomized programs
        for (int run = 0; run < 20; run++) begin
            fill_rom(3);
            do_reset();
            do_start();
            for (int n = 0; n < 60 && !m_halted; n++) rand_instr();
            if (m_halted) begin
                repeat (2) @(negedge clk);
                check("rand_halt_done", done, 1);
                check("rand_halt_pc", pc, m_pc);
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
